// File: rtl/norm_shift_pkg.sv
// Shared mode encoding and width helper for the normalising shifter pipeline.
package norm_shift_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_NORM  = 2'b10,
    MODE_PASS  = 2'b11
  } mode_e;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/lzc_n.sv
// Combinational leading-zero counter; count is 0 when the operand is all zeros.
module lzc_n
  import norm_shift_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int CNT_W = clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    count = '0;
    zero  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage shift/normalise pipeline: S1 resolves the shift amount, S2 applies
// a log2-staged barrel shift with sticky collection for right shifts.
module norm_shift_pipe
  import norm_shift_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int TAG_W = 4,
  localparam int AMT_W = clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [AMT_W-1:0] out_amt,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  mode_e             mode;
  logic [AMT_W-1:0]  lz_count;
  logic              lz_zero;
  logic [AMT_W-1:0]  eff_amt;

  logic              s1_full;
  logic [WIDTH-1:0]  s1_data;
  mode_e             s1_mode;
  logic [TAG_W-1:0]  s1_tag;
  logic [AMT_W-1:0]  s1_amt;
  logic              s1_zero;

  logic              s2_adv;
  logic [WIDTH-1:0]  sh_data;
  logic              sh_sticky;

  assign mode = mode_e'(in_mode);

  lzc_n #(.WIDTH(WIDTH)) u_lzc (
    .data  (in_data),
    .count (lz_count),
    .zero  (lz_zero)
  );

  always_comb begin
    case (mode)
      MODE_NORM: eff_amt = lz_zero ? '0 : lz_count;
      MODE_PASS: eff_amt = '0;
      default:   eff_amt = in_amt;
    endcase
  end

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_full || s2_adv);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full <= 1'b0;
      s1_data <= '0;
      s1_mode <= MODE_LEFT;
      s1_tag  <= '0;
      s1_amt  <= '0;
      s1_zero <= 1'b0;
    end else if (in_ready) begin
      s1_full <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode;
        s1_tag  <= in_tag;
        s1_amt  <= eff_amt;
        s1_zero <= lz_zero;
      end
    end
  end

  // Each stage k drops the low 2**k bits into sticky before shifting; masks
  // wider than the datapath saturate to all ones, covering over-range amounts.
  always_comb begin
    sh_data   = s1_data;
    sh_sticky = 1'b0;
    for (int unsigned k = 0; k < AMT_W; k++) begin
      if (s1_amt[k]) begin
        if (s1_mode == MODE_RIGHT) begin
          sh_sticky = sh_sticky | (|(sh_data & ~({WIDTH{1'b1}} << (1 << k))));
          sh_data   = sh_data >> (1 << k);
        end else begin
          sh_data   = sh_data << (1 << k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= 1'b0;
      out_amt    <= '0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_full;
      if (s1_full) begin
        out_data   <= sh_data;
        out_sticky <= sh_sticky;
        out_amt    <= s1_amt;
        out_zero   <= s1_zero;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe at WIDTH=24: directed vectors plus a
// randomised stream against a behavioural reference and an in-order scoreboard.
module tb_norm_shift_pipe;

  localparam int W  = 24;
  localparam int TW = 4;
  localparam int AW = 6;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          sticky;
    logic [AW-1:0] amt;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [1:0]    in_mode = 2'b00;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic [AW-1:0] out_amt;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  norm_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_amt    (out_amt),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic [AW-1:0] a,
                                 input logic [1:0] m, input logic [TW-1:0] t);
    exp_t e;
    int   lz;
    e.tag    = t;
    e.zero   = (d == '0);
    e.sticky = 1'b0;
    case (m)
      2'b00: begin
        e.amt  = a;
        e.data = (a >= W) ? '0 : d << a;
      end
      2'b01: begin
        e.amt  = a;
        e.data = (a >= W) ? '0 : d >> a;
        for (int i = 0; i < W; i++) if (i < int'(a) && d[i]) e.sticky = 1'b1;
      end
      2'b10: begin
        lz = 0;
        while (lz < W && !d[W-1-lz]) lz++;
        if (lz == W) begin
          e.data = '0;
          e.amt  = '0;
        end else begin
          e.data = d << lz;
          e.amt  = AW'(lz);
        end
      end
      default: begin
        e.data = d;
        e.amt  = '0;
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input logic s, input logic [AW-1:0] a,
                              input logic z, input logic [TW-1:0] t);
    exp_t e;
    e.data = d; e.sticky = s; e.amt = a; e.zero = z; e.tag = t;
    return e;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data",   out_data,   e.data);
        check("out_sticky", out_sticky, e.sticky);
        check("out_amt",    out_amt,    e.amt);
        check("out_zero",   out_zero,   e.zero);
        check("out_tag",    out_tag,    e.tag);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_rdy(input int m);
    rdy_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m,
                      input logic [TW-1:0] t, input exp_t e);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_tag   = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        accepted = 1;
        break;
      end
    end
    if (!accepted) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [1:0]    m;
    logic [TW-1:0] t;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_amt",   out_amt,   0);
    check("rst_out_tag",   out_tag,   0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    set_rdy(0);

    // Latency: LEFT 0x000001 << 23
    in_valid = 1'b1; in_data = 24'h000001; in_amt = 6'd23; in_mode = 2'b00; in_tag = 4'h0;
    @(negedge clk);
    check("lat_in_ready", in_ready, 1);
    sb.push_back(mk(24'h800000, 1'b0, 6'd23, 1'b0, 4'h0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_cycle1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_cycle2_data",  out_data,  24'h800000);
    repeat (2) @(posedge clk);
    #1;

    send(24'h800003, 6'd2,  2'b01, 4'h1, mk(24'h200000, 1'b1, 6'd2,  1'b0, 4'h1));
    send(24'h000001, 6'd30, 2'b01, 4'h2, mk(24'h000000, 1'b1, 6'd30, 1'b0, 4'h2));
    send(24'h000F00, 6'd5,  2'b10, 4'h3, mk(24'hF00000, 1'b0, 6'd12, 1'b0, 4'h3));
    send(24'h000000, 6'd9,  2'b10, 4'h4, mk(24'h000000, 1'b0, 6'd0,  1'b1, 4'h4));
    send(24'hABCDEF, 6'd24, 2'b00, 4'h5, mk(24'h000000, 1'b0, 6'd24, 1'b0, 4'h5));
    send(24'h123457, 6'd0,  2'b01, 4'h6, mk(24'h123457, 1'b0, 6'd0,  1'b0, 4'h6));
    send(24'hA5A5A5, 6'd7,  2'b11, 4'h7, mk(24'hA5A5A5, 1'b0, 6'd0,  1'b0, 4'h7));
    send(24'h800000, 6'd24, 2'b01, 4'h8, mk(24'h000000, 1'b1, 6'd24, 1'b0, 4'h8));
    send(24'h800000, 6'd3,  2'b10, 4'h9, mk(24'h800000, 1'b0, 6'd0,  1'b0, 4'h9));
    send(24'h000000, 6'd63, 2'b01, 4'hA, mk(24'h000000, 1'b0, 6'd63, 1'b1, 4'hA));
    send(24'h0000FF, 6'd4,  2'b01, 4'hB, mk(24'h00000F, 1'b1, 6'd4,  1'b0, 4'hB));
    send(24'h000001, 6'd0,  2'b00, 4'hC, mk(24'h000001, 1'b0, 6'd0,  1'b0, 4'hC));
    send(24'h000010, 6'd63, 2'b00, 4'hD, mk(24'h000000, 1'b0, 6'd63, 1'b0, 4'hD));
    repeat (4) @(posedge clk);
    #1;
    check("directed_drain", sb.size(), 0);

    // Backpressure: four tags streamed while out_ready is held low
    set_rdy(1);
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          d = W'(i * 17);
          send(d, 6'd0, 2'b11, TW'(i), mk(d, 1'b0, 6'd0, 1'b0, TW'(i)));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("stall_in_ready",  in_ready,  0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_tag",   out_tag,   1);
        repeat (2) begin
          @(posedge clk);
          #1;
          check("stall_hold_data", out_data, 24'h000011);
          check("stall_hold_tag",  out_tag,  1);
          check("stall_hold_rdy",  in_ready, 0);
        end
        rdy_mode = 0;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stall_drain", sb.size(), 0);

    // Reset with two items in flight
    set_rdy(1);
    send(24'h000123, 6'd1, 2'b00, 4'h5, mk(24'h000246, 1'b0, 6'd1, 1'b0, 4'h5));
    send(24'h000456, 6'd1, 2'b00, 4'h6, mk(24'h0008AC, 1'b0, 6'd1, 1'b0, 4'h6));
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready",  in_ready,  0);
    check("mid_rst_out_tag",   out_tag,   0);
    rst = 1'b0;
    #1;
    check("rel_rst_in_ready", in_ready, 1);
    rdy_mode = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", out_valid, 0);
    end

    // Random stream with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      d = W'($urandom) >> $urandom_range(0, 23);
      if ($urandom_range(0, 31) == 0) d = '0;
      a = AW'($urandom_range(0, 63));
      m = 2'($urandom_range(0, 3));
      t = TW'(i);
      send(d, a, m, t, model(d, a, m, t));
    end
    rdy_mode = 0;
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("random_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
